servo_pwm_bank: RTL and testbench
=================================

// Module: servo_pwm_bank
// PURPOSE
//   N-channel hobby-servo PWM generator for the UDAR scan head; replaces the fixed two-servo outputs.
//   Positions arrive as 8-bit words over a valid/ready write port fed by the serial command decoder.
//   Pending positions are double-buffered and applied only at frame boundaries (glitch-free pulses).
//   All channels share one frame counter; frame_start lets the ultrasonic trigger align to servo motion.
// PARAMETERS
//   NUM_CH      4          number of servo outputs (1..16)
//   PERIOD_CYC  1_000_000  frame length in clk cycles (20 ms @ 50 MHz)
//   MIN_PULSE   50_000     pulse width for position 0 (1 ms)
//   STEP_CYC    196        extra pulse cycles per position LSB (pos 255 ~ 2 ms)
//   CENTER_POS  128        reset position of every channel
//   SLEW_STEP   4          max position change per frame (used only with SERVO_SLEW_EN)
//   Legal only if MIN_PULSE + 255*STEP_CYC < PERIOD_CYC; simulation $fatal otherwise.
// PORTS
//   clk          in   1          system clock
//   rst_n        in   1          asynchronous reset, active low
//   wr_valid     in   1          position write request
//   wr_ready     out  1          write accepted when wr_valid && wr_ready
//   wr_ch        in   CH_W       target channel, CH_W = max(1,$clog2(NUM_CH))
//   wr_pos       in   8          target position 0..255
//   ch_en        in   NUM_CH     per-channel enable, sampled at frame boundary
//   pwm          out  NUM_CH     servo pulse outputs, registered
//   frame_start  out  1          one-cycle pulse, first cycle of each frame
//   wr_err       out  1          one-cycle pulse: write accepted with wr_ch >= NUM_CH
// BEHAVIOUR
//   Reset: cnt=0; pending[i]=active[i]=CENTER_POS; en_act=0; pwm=0; frame_start=0; wr_err=0; wr_ready=0.
//   cnt: $clog2(PERIOD_CYC) bits, increments every clk, wraps PERIOD_CYC-1 -> 0.
//   Boundary cycle = cnt==PERIOD_CYC-1: active[i]<=pending[i] (or slewed), en_act<=ch_en.
//   wr_ready = 1 except in boundary cycle (=0); no write/latch collision possible.
//   Accepted write: pending[wr_ch]<=wr_pos next cycle; later write to same ch before boundary overwrites.
//   wr_ch >= NUM_CH: accepted (ready honoured), no register change, wr_err pulses next cycle.
//   Width W[i] = MIN_PULSE + active[i]*STEP_CYC, unsigned, width $clog2(PERIOD_CYC) bits, no overflow by param rule.
//   pwm[i] next = en_act[i] && (cnt < W[i]); 1-cycle latency: pwm high from cycle after cnt==0 for W[i] cycles.
//   frame_start registered: high the cycle after cnt==0 (aligned with pwm rising edge).
//   Channel disabled mid-frame via ch_en: current pulse completes; takes effect next frame.
//   Reset mid-pulse: pwm drops immediately (async); first frame after reset has en_act=0, all outputs low.
//   Position written in boundary cycle is stalled (wr_ready=0) and lands in the following frame's pending.
// CONFIGURATION
//   SERVO_SLEW_EN defined: at boundary active[i] moves toward pending[i] by min(|diff|,SLEW_STEP);
//     never overshoots; equal -> unchanged. Reset still loads CENTER_POS directly.
//   SERVO_SLEW_EN undefined: active[i]<=pending[i] directly; SLEW_STEP ignored.
// STRUCTURE
//   Package servo_pkg: POS_W=8, width function pulse_cyc(pos,MIN_PULSE,STEP_CYC), CH_W calc function.
//   Sub-module servo_channel (one per channel, generate loop): pending/active regs, slew logic,
//     comparator, pwm flop. Top holds frame counter, write decode, wr_ready/wr_err, frame_start.
// TESTING (sim params: NUM_CH=4, PERIOD_CYC=1000, MIN_PULSE=100, STEP_CYC=2, CENTER_POS=128)
//   Reset, ch_en=4'hF -> frame 1 pwm all low; frame 2 all pulses 356 cycles wide, frame_start every 1000.
//   Write ch2=0, ch3=255 mid-frame -> current frame unchanged; next frame ch2=100, ch3=610 cycles.
//   wr_valid held across cnt==999 -> wr_ready=0 that cycle only; write accepted at cnt==0, applied frame+1.
//   wr_ch=4 (NUM_CH=4 uses CH_W=2, so use NUM_CH=3 build, wr_ch=3) -> wr_err pulse, no pwm change.
//   ch_en[1] dropped mid-pulse -> pulse finishes; ch1 low from next frame; re-enable restores width.
//   SERVO_SLEW_EN, SLEW_STEP=4: ch0 128->140 -> widths 364,372,380 then 380 steady (3 frames).
//   Assert rst_n low mid-pulse -> pwm=0 same cycle; after release behaves as first bullet.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared types and helpers for the servo PWM bank: position width, pulse-width
// arithmetic and channel-select width calculation.
package servo_pkg;

    localparam int unsigned POS_W = 8;

    // Select width for a given channel count; a single channel still gets one bit.
    function automatic int unsigned ch_w_calc(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Pulse length in clock cycles for a servo position.
    function automatic int unsigned pulse_cyc(input logic [POS_W-1:0] pos,
                                              input int unsigned      min_pulse,
                                              input int unsigned      step_cyc);
        return min_pulse + 32'(pos) * step_cyc;
    endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo output: double-buffered position (pending/active), optional slew
// limiting (SERVO_SLEW_EN), frame-latched enable and registered pulse comparator.
module servo_channel
    import servo_pkg::*;
#(
    parameter int unsigned      CNT_W      = 10,
    parameter int unsigned      MIN_PULSE  = 100,
    parameter int unsigned      STEP_CYC   = 2,
`ifdef SERVO_SLEW_EN
    parameter int unsigned      SLEW_STEP  = 4,
`endif
    parameter logic [POS_W-1:0] CENTER_POS = 8'd128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             boundary,
    input  logic             wr_en,
    input  logic [POS_W-1:0] wr_pos,
    input  logic             ch_en,
    input  logic [CNT_W-1:0] cnt,
    output logic             pwm
);

    logic [POS_W-1:0] pending;
    logic [POS_W-1:0] active;
    logic [POS_W-1:0] active_nxt;
    logic             en_act;
    logic [CNT_W-1:0] width;

`ifdef SERVO_SLEW_EN
    localparam logic [POS_W-1:0] STEP = POS_W'(SLEW_STEP);

    // Move toward the pending position by at most STEP, landing exactly on it.
    always_comb begin
        active_nxt = active;
        if (pending > active) begin
            active_nxt = ((pending - active) > STEP) ? (active + STEP) : pending;
        end else if (pending < active) begin
            active_nxt = ((active - pending) > STEP) ? (active - STEP) : pending;
        end
    end
`else
    assign active_nxt = pending;
`endif

    assign width = CNT_W'(pulse_cyc(active, MIN_PULSE, STEP_CYC));

    // Position and enable only change at the frame boundary, so a pulse never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= CENTER_POS;
            active  <= CENTER_POS;
            en_act  <= 1'b0;
            pwm     <= 1'b0;
        end else begin
            if (wr_en) begin
                pending <= wr_pos;
            end
            if (boundary) begin
                active <= active_nxt;
                en_act <= ch_en;
            end
            pwm <= en_act && (cnt < width);
        end
    end

endmodule

// File: rtl/servo_pwm_bank.sv
// N-channel hobby-servo PWM bank with a shared frame counter and valid/ready
// position writes. Define SERVO_SLEW_EN to rate-limit position changes per frame.
module servo_pwm_bank
    import servo_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned PERIOD_CYC = 1_000_000,
    parameter int unsigned MIN_PULSE  = 50_000,
    parameter int unsigned STEP_CYC   = 196,
    parameter int unsigned CENTER_POS = 128,
    parameter int unsigned SLEW_STEP  = 4,
    localparam int unsigned CH_W      = ch_w_calc(NUM_CH),
    localparam int unsigned CNT_W     = $clog2(PERIOD_CYC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [POS_W-1:0]  wr_pos,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] pwm,
    output logic              frame_start,
    output logic              wr_err
);

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $fatal(1, "servo_pwm_bank: NUM_CH must be 1..16");
    end
    if (MIN_PULSE + 255 * STEP_CYC >= PERIOD_CYC) begin : g_bad_period
        $fatal(1, "servo_pwm_bank: longest pulse must be shorter than PERIOD_CYC");
    end
    if (CENTER_POS > 255 || SLEW_STEP < 1 || SLEW_STEP > 255) begin : g_bad_pos
        $fatal(1, "servo_pwm_bank: CENTER_POS and SLEW_STEP must fit a position");
    end

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              boundary;
    logic              wr_acc;
    logic [NUM_CH-1:0] ch_wr_en;

    assign boundary = (cnt == CNT_W'(PERIOD_CYC - 1));
    assign cnt_nxt  = boundary ? '0 : (cnt + CNT_W'(1));
    assign wr_acc   = wr_valid && wr_ready;

    // wr_ready is precomputed so it is low exactly during the boundary cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            wr_ready    <= 1'b0;
            frame_start <= 1'b0;
            wr_err      <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            wr_ready    <= (cnt_nxt != CNT_W'(PERIOD_CYC - 1));
            frame_start <= (cnt == '0);
            wr_err      <= wr_acc && (32'(wr_ch) >= NUM_CH);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ch_wr_en[i] = wr_acc && (wr_ch == CH_W'(i));

        servo_channel #(
            .CNT_W      (CNT_W),
            .MIN_PULSE  (MIN_PULSE),
            .STEP_CYC   (STEP_CYC),
`ifdef SERVO_SLEW_EN
            .SLEW_STEP  (SLEW_STEP),
`endif
            .CENTER_POS (POS_W'(CENTER_POS))
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .boundary (boundary),
            .wr_en    (ch_wr_en[i]),
            .wr_pos   (wr_pos),
            .ch_en    (ch_en[i]),
            .cnt      (cnt),
            .pwm      (pwm[i])
        );
    end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Directed bench for servo_pwm_bank: a 4-channel instance plus a 3-channel
// instance for out-of-range writes, both with a 1000-cycle frame.
module tb_servo_pwm_bank;

    localparam int unsigned PERIOD = 1000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [1:0] wr_ch = '0;
    logic [7:0] wr_pos = '0;
    logic [3:0] ch_en = '0;
    logic [3:0] pwm;
    logic       frame_start;
    logic       wr_err;

    logic       wr3_valid = 1'b0;
    logic       wr3_ready;
    logic [1:0] wr3_ch = '0;
    logic [7:0] wr3_pos = '0;
    logic [2:0] ch3_en = '0;
    logic [2:0] pwm3;
    logic       frame_start3;
    logic       wr_err3;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_w[4];
    int exp_w3[3];

    always #5 clk = ~clk;

    servo_pwm_bank #(
        .NUM_CH(4), .PERIOD_CYC(1000), .MIN_PULSE(100), .STEP_CYC(2),
        .CENTER_POS(128), .SLEW_STEP(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_ch(wr_ch), .wr_pos(wr_pos), .ch_en(ch_en), .pwm(pwm),
        .frame_start(frame_start), .wr_err(wr_err)
    );

    servo_pwm_bank #(
        .NUM_CH(3), .PERIOD_CYC(1000), .MIN_PULSE(100), .STEP_CYC(2),
        .CENTER_POS(128), .SLEW_STEP(4)
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr3_valid), .wr_ready(wr3_ready),
        .wr_ch(wr3_ch), .wr_pos(wr3_pos), .ch_en(ch3_en), .pwm(pwm3),
        .frame_start(frame_start3), .wr_err(wr_err3)
    );

    // Waits for frame_start, then counts high cycles per channel over one frame.
    task automatic measure_frame(output int w[4], output int w3[3],
                                 output int gap, output int extra);
        gap = 0;
        extra = 0;
        for (int c = 0; c < 4; c++) w[c] = 0;
        for (int c = 0; c < 3; c++) w3[c] = 0;
        while (frame_start !== 1'b1 && gap < 3000) begin
            @(negedge clk);
            gap++;
        end
        n_cmp++;
        if (frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_start_wait: got no pulse in %0d cycles, expected one", gap);
        end
        for (int i = 0; i < PERIOD; i++) begin
            for (int c = 0; c < 4; c++) if (pwm[c] === 1'b1) w[c]++;
            for (int c = 0; c < 3; c++) if (pwm3[c] === 1'b1) w3[c]++;
            if (i != 0 && (frame_start === 1'b1 || frame_start3 === 1'b1)) extra++;
            @(negedge clk);
        end
    endtask

    task automatic do_write(input logic [1:0] ch, input logic [7:0] pos);
        int n;
        wr_valid = 1'b1;
        wr_ch = ch;
        wr_pos = pos;
        n = 0;
        while (wr_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL write_ready_wait: got ready=%b, expected 1 within 10 cycles", wr_ready);
        end
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        int w[4]; int w3[3]; int gap; int extra;
        rst_n = 1'b0;
        ch_en = 4'hF;
        ch3_en = 3'h7;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({pwm, frame_start, wr_ready, wr_err} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got pwm=%b fs=%b rdy=%b err=%b, expected all 0",
                     pwm, frame_start, wr_ready, wr_err);
        end
        n_cmp++;
        if ({pwm3, wr3_ready, wr_err3} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs3: got pwm3=%b rdy=%b err=%b, expected all 0",
                     pwm3, wr3_ready, wr_err3);
        end
        rst_n = 1'b1;
        measure_frame(w, w3, gap, extra);
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if (w[c] !== 0) begin
                n_fail++;
                $display("FAIL reset_frame1_ch%0d: got width %0d, expected 0", c, w[c]);
            end
        end
        exp_w = '{356, 356, 356, 356};
        exp_w3 = '{356, 356, 356};
        measure_frame(w, w3, gap, extra);
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if (w[c] !== exp_w[c]) begin
                n_fail++;
                $display("FAIL reset_frame2_ch%0d: got width %0d, expected %0d", c, w[c], exp_w[c]);
            end
        end
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (w3[c] !== exp_w3[c]) begin
                n_fail++;
                $display("FAIL reset_frame2_dut3_ch%0d: got width %0d, expected %0d", c, w3[c], exp_w3[c]);
            end
        end
        n_cmp++;
        if (gap !== 0 || extra !== 0) begin
            n_fail++;
            $display("FAIL frame_period: got gap=%0d extra=%0d, expected 0 and 0", gap, extra);
        end
    endtask

    task automatic test_write_mid_frame();
        int w[4]; int w3[3]; int gap; int extra;
        fork
            measure_frame(w, w3, gap, extra);
            begin
                repeat (200) @(negedge clk);
                do_write(2'd2, 8'd0);
                do_write(2'd3, 8'd255);
            end
        join
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if (w[c] !== exp_w[c]) begin
                n_fail++;
                $display("FAIL midwrite_cur_ch%0d: got width %0d, expected %0d", c, w[c], exp_w[c]);
            end
        end
        exp_w = '{356, 356, 100, 610};
        measure_frame(w, w3, gap, extra);
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if (w[c] !== exp_w[c]) begin
                n_fail++;
                $display("FAIL midwrite_next_ch%0d: got width %0d, expected %0d", c, w[c], exp_w[c]);
            end
        end
        n_cmp++;
        if (gap !== 0 || extra !== 0) begin
            n_fail++;
            $display("FAIL midwrite_period: got gap=%0d extra=%0d, expected 0 and 0", gap, extra);
        end
    endtask

    // Entered at the first cycle of a frame (counter value 1).
    task automatic test_boundary_stall();
        int w[4]; int w3[3]; int gap; int extra;
        repeat (997) @(negedge clk);
        n_cmp++;
        if (wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_pre_ready: got %b, expected 1", wr_ready);
        end
        @(negedge clk);
        wr_valid = 1'b1;
        wr_ch = 2'd1;
        wr_pos = 8'd200;
        n_cmp++;
        if (wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_boundary_ready: got %b, expected 0", wr_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_post_ready: got %b, expected 1", wr_ready);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        n_cmp++;
        if (frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_frame_align: got frame_start=%b, expected 1", frame_start);
        end
        measure_frame(w, w3, gap, extra);
        n_cmp++;
        if (w[1] !== 356) begin
            n_fail++;
            $display("FAIL stall_frame_a_ch1: got width %0d, expected 356", w[1]);
        end
        exp_w = '{356, 500, 100, 610};
        measure_frame(w, w3, gap, extra);
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if (w[c] !== exp_w[c]) begin
                n_fail++;
                $display("FAIL stall_frame_b_ch%0d: got width %0d, expected %0d", c, w[c], exp_w[c]);
            end
        end
    endtask

    task automatic test_wr_err();
        int w[4]; int w3[3]; int gap; int extra;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (wr3_ready !== 1'b1 || wr_err3 !== 1'b0) begin
            n_fail++;
            $display("FAIL err_pre: got rdy=%b err=%b, expected 1 and 0", wr3_ready, wr_err3);
        end
        wr3_valid = 1'b1;
        wr3_ch = 2'd3;
        wr3_pos = 8'd0;
        @(negedge clk);
        wr3_valid = 1'b0;
        n_cmp++;
        if (wr_err3 !== 1'b1) begin
            n_fail++;
            $display("FAIL err_pulse: got %b, expected 1", wr_err3);
        end
        n_cmp++;
        if (wr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_other_dut: got %b, expected 0", wr_err);
        end
        @(negedge clk);
        n_cmp++;
        if (wr_err3 !== 1'b0) begin
            n_fail++;
            $display("FAIL err_one_cycle: got %b, expected 0", wr_err3);
        end
        measure_frame(w, w3, gap, extra);
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (w3[c] !== exp_w3[c]) begin
                n_fail++;
                $display("FAIL err_nochange_ch%0d: got width %0d, expected %0d", c, w3[c], exp_w3[c]);
            end
        end
    endtask

    task automatic test_ch_en();
        int w[4]; int w3[3]; int gap; int extra;
        fork
            measure_frame(w, w3, gap, extra);
            begin
                repeat (100) @(negedge clk);
                ch_en[1] = 1'b0;
            end
        join
        n_cmp++;
        if (w[1] !== 500) begin
            n_fail++;
            $display("FAIL chen_drop_finish: got width %0d, expected 500", w[1]);
        end
        fork
            measure_frame(w, w3, gap, extra);
            begin
                repeat (100) @(negedge clk);
                ch_en[1] = 1'b1;
            end
        join
        n_cmp++;
        if (w[1] !== 0) begin
            n_fail++;
            $display("FAIL chen_off_frame: got width %0d, expected 0", w[1]);
        end
        n_cmp++;
        if (w[0] !== 356) begin
            n_fail++;
            $display("FAIL chen_neighbour: got width %0d, expected 356", w[0]);
        end
        measure_frame(w, w3, gap, extra);
        n_cmp++;
        if (w[1] !== 500) begin
            n_fail++;
            $display("FAIL chen_restore: got width %0d, expected 500", w[1]);
        end
    endtask

    task automatic test_slew();
        int w[4]; int w3[3]; int gap; int extra;
        int exp0[4];
`ifdef SERVO_SLEW_EN
        exp0 = '{364, 372, 380, 380};
`else
        exp0 = '{380, 380, 380, 380};
`endif
        repeat (5) @(negedge clk);
        do_write(2'd0, 8'd140);
        for (int f = 0; f < 4; f++) begin
            measure_frame(w, w3, gap, extra);
            n_cmp++;
            if (w[0] !== exp0[f]) begin
                n_fail++;
                $display("FAIL slew_frame%0d_ch0: got width %0d, expected %0d", f, w[0], exp0[f]);
            end
        end
        n_cmp++;
        if (w[3] !== 610) begin
            n_fail++;
            $display("FAIL slew_other_ch3: got width %0d, expected 610", w[3]);
        end
    endtask

    task automatic test_reset_mid_pulse();
        int w[4]; int w3[3]; int gap; int extra;
        repeat (50) @(negedge clk);
        n_cmp++;
        if (pwm !== 4'hF) begin
            n_fail++;
            $display("FAIL midrst_pre_pulse: got pwm=%b, expected 1111", pwm);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (pwm !== 4'h0 || pwm3 !== 3'h0) begin
            n_fail++;
            $display("FAIL midrst_async: got pwm=%b pwm3=%b, expected 0", pwm, pwm3);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        measure_frame(w, w3, gap, extra);
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if (w[c] !== 0) begin
                n_fail++;
                $display("FAIL midrst_frame1_ch%0d: got width %0d, expected 0", c, w[c]);
            end
        end
        exp_w = '{356, 356, 356, 356};
        measure_frame(w, w3, gap, extra);
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if (w[c] !== exp_w[c]) begin
                n_fail++;
                $display("FAIL midrst_frame2_ch%0d: got width %0d, expected %0d", c, w[c], exp_w[c]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion by 2 ms, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write_mid_frame();
        test_boundary_stall();
        test_wr_err();
        test_ch_en();
        test_slew();
        test_reset_mid_pulse();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
